// File: rtl/move_multi.sv
// Cursor mover over a configurable slot range, driven by PS/2 arrow scancodes,
// with held-key auto-repeat and a commit/lock handshake. Define MOVE_MULTI_WRAP_EN for wrap-around steps.
module move_multi #(
  parameter int unsigned POS_W         = 3,
  parameter int unsigned NARROW_SLOTS  = 4,
  parameter int unsigned WIDE_SLOTS    = 8,
  parameter int unsigned START_POS     = 0,
  parameter logic [7:0]  KEY_LEFT      = 8'h6B,
  parameter logic [7:0]  KEY_RIGHT     = 8'h74,
  parameter logic [1:0]  ACTIVE_SCENE  = 2'd1,
  parameter int unsigned REPEAT_DELAY  = 25_000_000,
  parameter int unsigned REPEAT_PERIOD = 5_000_000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       scene,
  input  logic             scene_posedge,
  input  logic [7:0]       key,
  input  logic             key_released,
  input  logic             done_posedge,
  input  logic             expand,
  output logic [POS_W-1:0] pos,
  output logic [POS_W-1:0] people,
  output logic             commit,
  output logic             locked
);

  localparam int unsigned CNT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX);

  localparam logic [CNT_W-1:0] DELAY_END  = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] PERIOD_END = CNT_W'(REPEAT_PERIOD - 1);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
  localparam logic [POS_W-1:0] NARROW_LIM = POS_W'(NARROW_SLOTS - 1);
  localparam logic [POS_W-1:0] WIDE_LIM   = POS_W'(WIDE_SLOTS - 1);
  localparam logic [POS_W-1:0] START_P    = POS_W'(START_POS);
  localparam logic [POS_W-1:0] POS_ONE    = POS_W'(1);

  typedef enum logic [2:0] {IDLE, READY, DELAY, REPEAT, LOCKED} state_t;

  state_t           state, mv_state;
  logic [CNT_W-1:0] cnt, mv_cnt;
  logic [7:0]       prev_key;
  logic             prev_held;

  logic             held, is_arrow, press, active, mv_step;
  logic [POS_W-1:0] lim, step_pos, step_clamped, hold_clamped, mv_pos;

  assign held     = !key_released;
  assign is_arrow = (key == KEY_LEFT) || (key == KEY_RIGHT);
  assign press    = held && (!prev_held || (key != prev_key)) && is_arrow;
  assign active   = (scene == ACTIVE_SCENE);
  assign lim      = expand ? WIDE_LIM : NARROW_LIM;

  always_comb begin
    step_pos = pos;
    if (key == KEY_LEFT) begin
      if (pos == '0) begin
`ifdef MOVE_MULTI_WRAP_EN
        step_pos = lim;
`else
        step_pos = '0;
`endif
      end else begin
        step_pos = pos - POS_ONE;
      end
    end else if (key == KEY_RIGHT) begin
      if (pos >= lim) begin
`ifdef MOVE_MULTI_WRAP_EN
        step_pos = '0;
`else
        step_pos = lim;
`endif
      end else begin
        step_pos = pos + POS_ONE;
      end
    end
  end

  // Clamp is applied after the step so a shrinking range pulls pos back in.
  assign step_clamped = (step_pos > lim) ? lim : step_pos;
  assign hold_clamped = (pos > lim) ? lim : pos;

  always_comb begin
    mv_step  = 1'b0;
    mv_state = state;
    mv_cnt   = cnt;
    case (state)
      READY: begin
        if (press) begin
          mv_step  = 1'b1;
          mv_state = DELAY;
          mv_cnt   = '0;
        end
      end
      DELAY, REPEAT: begin
        if (!held || !is_arrow) begin
          mv_state = READY;
          mv_cnt   = '0;
        end else if (press) begin
          mv_step  = 1'b1;
          mv_state = DELAY;
          mv_cnt   = '0;
        end else if (cnt == ((state == DELAY) ? DELAY_END : PERIOD_END)) begin
          mv_step  = 1'b1;
          mv_state = REPEAT;
          mv_cnt   = '0;
        end else begin
          mv_cnt = cnt + CNT_ONE;
        end
      end
      default: ;
    endcase
    mv_pos = mv_step ? step_clamped : hold_clamped;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      prev_key  <= '0;
      prev_held <= 1'b0;
      pos       <= START_P;
      people    <= '0;
      commit    <= 1'b0;
      locked    <= 1'b0;
    end else begin
      prev_key  <= key;
      prev_held <= held;
      commit    <= 1'b0;
      if (scene_posedge) begin
        pos    <= START_P;
        locked <= 1'b0;
        cnt    <= '0;
        state  <= active ? READY : IDLE;
      end else if (!active) begin
        state  <= IDLE;
        pos    <= hold_clamped;
        locked <= 1'b0;
        cnt    <= '0;
      end else begin
        case (state)
          IDLE: begin
            state <= READY;
            pos   <= hold_clamped;
          end
          LOCKED: pos <= hold_clamped;
          default: begin
            pos <= mv_pos;
            if (done_posedge) begin
              people <= mv_pos;
              commit <= 1'b1;
              locked <= 1'b1;
              state  <= LOCKED;
              cnt    <= '0;
            end else begin
              state <= mv_state;
              cnt   <= mv_cnt;
            end
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_move_multi.sv
// Table-driven bench for move_multi with short repeat timing (delay 4, period 3).
module tb_move_multi;

  localparam logic [7:0] KR = 8'h74;
  localparam logic [7:0] KL = 8'h6B;
`ifdef MOVE_MULTI_WRAP_EN
  localparam bit WRAP = 1'b1;
`else
  localparam bit WRAP = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n, scene_posedge, key_released, done_posedge, expand;
  logic [1:0] scene;
  logic [7:0] key;
  logic [2:0] pos, people;
  logic       commit, locked;

  int checks = 0;
  int errors = 0;

  move_multi #(
    .POS_W(3), .NARROW_SLOTS(4), .WIDE_SLOTS(8), .START_POS(0),
    .KEY_LEFT(8'h6B), .KEY_RIGHT(8'h74), .ACTIVE_SCENE(2'd1),
    .REPEAT_DELAY(4), .REPEAT_PERIOD(3)
  ) dut (
    .clk(clk), .rst_n(rst_n), .scene(scene), .scene_posedge(scene_posedge),
    .key(key), .key_released(key_released), .done_posedge(done_posedge),
    .expand(expand), .pos(pos), .people(people), .commit(commit), .locked(locked)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst_n;
    logic [1:0] scene;
    logic       sp;
    logic [7:0] key;
    logic       kr;
    logic       done;
    logic       expand;
    logic [2:0] e_pos;
    logic [2:0] e_people;
    logic       e_commit;
    logic       e_locked;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(input logic r, input logic [1:0] sc, input logic sp,
                              input logic [7:0] k, input logic kr, input logic d,
                              input logic ex, input logic [2:0] ep, input logic [2:0] epl,
                              input logic ec, input logic el);
    vec_t v;
    v.rst_n = r; v.scene = sc; v.sp = sp; v.key = k; v.kr = kr; v.done = d;
    v.expand = ex; v.e_pos = ep; v.e_people = epl; v.e_commit = ec; v.e_locked = el;
    tbl.push_back(v);
  endfunction

  task automatic chk(input string name, input int idx, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s step %0d got %0d expected %0d", name, idx, got, exp);
    end
  endtask

  task automatic apply(input vec_t v, input int idx);
    @(negedge clk);
    rst_n = v.rst_n; scene = v.scene; scene_posedge = v.sp; key = v.key;
    key_released = v.kr; done_posedge = v.done; expand = v.expand;
    @(posedge clk);
    #1;
    chk("pos", idx, 8'(pos), 8'(v.e_pos));
    chk("people", idx, 8'(people), 8'(v.e_people));
    chk("commit", idx, 8'(commit), 8'(v.e_commit));
    chk("locked", idx, 8'(locked), 8'(v.e_locked));
  endtask

  initial begin
    logic [2:0] wl, wr;
    vec_t hv;
    wl = WRAP ? 3'd3 : 3'd0;
    wr = WRAP ? 3'd0 : 3'd1;
    rst_n = 1'b0; scene = 2'd0; scene_posedge = 1'b0; key = 8'h00;
    key_released = 1'b1; done_posedge = 1'b0; expand = 1'b0;

    //   rst sc sp key kr dn ex  pos ppl cm lk
    add(0, 0, 0, 8'h00, 1, 0, 0, 0, 0, 0, 0);
    add(1, 1, 1, 8'h00, 1, 0, 0, 0, 0, 0, 0);
    add(1, 1, 0, KR, 0, 0, 0, 1, 0, 0, 0);
    add(1, 1, 0, KR, 1, 0, 0, 1, 0, 0, 0);
    add(1, 1, 0, KR, 1, 0, 0, 1, 0, 0, 0);
    add(1, 1, 0, KR, 0, 0, 0, 2, 0, 0, 0);
    add(1, 1, 0, KR, 1, 0, 0, 2, 0, 0, 0);
    add(1, 1, 0, KR, 0, 0, 0, 3, 0, 0, 0);
    add(1, 1, 0, KR, 1, 0, 0, 3, 0, 0, 0);
    add(1, 1, 0, KR, 0, 0, 0, 3, 0, 0, 0);
    add(1, 1, 0, KR, 1, 0, 0, 3, 0, 0, 0);
    add(1, 1, 0, KR, 0, 0, 1, 4, 0, 0, 0);
    add(1, 1, 0, KR, 1, 0, 1, 4, 0, 0, 0);
    add(1, 1, 0, KR, 1, 0, 0, 3, 0, 0, 0);
    // held right from 0: press, first repeat after 4 cycles, then every 3
    add(1, 1, 1, KR, 1, 0, 1, 0, 0, 0, 0);
    add(1, 1, 0, KR, 0, 0, 1, 1, 0, 0, 0);
    add(1, 1, 0, KR, 0, 0, 1, 1, 0, 0, 0);
    add(1, 1, 0, KR, 0, 0, 1, 1, 0, 0, 0);
    add(1, 1, 0, KR, 0, 0, 1, 1, 0, 0, 0);
    add(1, 1, 0, KR, 0, 0, 1, 2, 0, 0, 0);
    for (int p = 3; p <= 7; p++) begin
      add(1, 1, 0, KR, 0, 0, 1, 3'(p - 1), 0, 0, 0);
      add(1, 1, 0, KR, 0, 0, 1, 3'(p - 1), 0, 0, 0);
      add(1, 1, 0, KR, 0, 0, 1, 3'(p), 0, 0, 0);
    end
    add(1, 1, 0, KR, 0, 0, 1, 7, 0, 0, 0);
    add(1, 1, 0, KR, 0, 0, 1, 7, 0, 0, 0);
    add(1, 1, 0, KR, 0, 0, 1, 7, 0, 0, 0);
    add(1, 1, 0, KR, 1, 0, 1, 7, 0, 0, 0);
    add(1, 1, 0, KR, 1, 0, 1, 7, 0, 0, 0);
    add(1, 1, 0, KR, 1, 0, 1, 7, 0, 0, 0);
    add(1, 1, 0, KR, 1, 0, 1, 7, 0, 0, 0);
    // commit at 2, locked ignores presses, scene entry unlocks
    add(1, 1, 1, KR, 1, 0, 1, 0, 0, 0, 0);
    add(1, 1, 0, KR, 0, 0, 1, 1, 0, 0, 0);
    add(1, 1, 0, KR, 1, 0, 1, 1, 0, 0, 0);
    add(1, 1, 0, KR, 0, 0, 1, 2, 0, 0, 0);
    add(1, 1, 0, KR, 1, 0, 1, 2, 0, 0, 0);
    add(1, 1, 0, KR, 1, 1, 1, 2, 2, 1, 1);
    add(1, 1, 0, KR, 1, 0, 1, 2, 2, 0, 1);
    add(1, 1, 0, KL, 0, 0, 1, 2, 2, 0, 1);
    add(1, 1, 0, KL, 1, 0, 1, 2, 2, 0, 1);
    add(1, 1, 1, KL, 1, 0, 1, 0, 2, 0, 0);
    // scene strobe beats done in the same cycle
    add(1, 1, 0, KR, 0, 0, 1, 1, 2, 0, 0);
    add(1, 1, 0, KR, 1, 0, 1, 1, 2, 0, 0);
    add(1, 1, 1, KR, 1, 1, 1, 0, 2, 0, 0);
    // reset in the middle of auto-repeat
    add(1, 1, 0, KR, 0, 0, 1, 1, 2, 0, 0);
    add(1, 1, 0, KR, 0, 0, 1, 1, 2, 0, 0);
    add(1, 1, 0, KR, 0, 0, 1, 1, 2, 0, 0);
    add(1, 1, 0, KR, 0, 0, 1, 1, 2, 0, 0);
    add(1, 1, 0, KR, 0, 0, 1, 2, 2, 0, 0);
    add(1, 1, 0, KR, 0, 0, 1, 2, 2, 0, 0);
    add(0, 1, 0, KR, 0, 0, 1, 0, 0, 0, 0);
    add(1, 1, 1, KR, 1, 0, 1, 0, 0, 0, 0);
    // edge behaviour at 0 in the narrow range
    add(1, 1, 0, KL, 0, 0, 0, wl, 0, 0, 0);
    add(1, 1, 0, KL, 1, 0, 0, wl, 0, 0, 0);
    add(1, 1, 0, KR, 0, 0, 0, wr, 0, 0, 0);
    // leaving the active scene without a strobe
    add(1, 0, 0, KR, 1, 0, 0, wr, 0, 0, 0);
    add(1, 0, 0, KR, 0, 0, 0, wr, 0, 0, 0);
    add(1, 0, 0, KR, 1, 1, 0, wr, 0, 0, 0);
    // different arrow while held restarts with a fresh step
    add(1, 1, 1, KR, 1, 0, 1, 0, 0, 0, 0);
    add(1, 1, 0, KR, 0, 0, 1, 1, 0, 0, 0);
    add(1, 1, 0, KR, 0, 0, 1, 1, 0, 0, 0);
    add(1, 1, 0, KL, 0, 0, 1, 0, 0, 0, 0);
    add(1, 1, 0, KL, 0, 0, 1, 0, 0, 0, 0);
    add(1, 1, 0, KL, 1, 0, 1, 0, 0, 0, 0);

    foreach (tbl[i]) apply(tbl[i], i);

    // done on the same edge as a press commits the stepped position
    hv.rst_n = 1; hv.scene = 2'd1; hv.sp = 0; hv.key = KR; hv.kr = 0; hv.done = 1;
    hv.expand = 1; hv.e_pos = 1; hv.e_people = 1; hv.e_commit = 1; hv.e_locked = 1;
    apply(hv, 1000);
    hv.kr = 1; hv.done = 0; hv.e_commit = 0;
    apply(hv, 1001);
    hv.done = 1;
    apply(hv, 1002);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
